// File: rtl/l2_port_arbiter_pkg.sv
// Shared definitions for the L2 port arbiter: FSM state encoding, requester indices, default sizes.
package l2_port_arbiter_pkg;

  localparam int L2_BEATS    = 8;
  localparam int L2_CNT_BITS = 3;
  localparam int L2_DATA_W   = 32;
  localparam int L2_ADDR_W   = 32;

  localparam logic [1:0] REQ_I  = 2'd0;
  localparam logic [1:0] REQ_DR = 2'd1;
  localparam logic [1:0] REQ_DW = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARB   = 2'b01,
    ST_BURST = 2'b10,
    ST_DONE  = 2'b11
  } arb_state_t;

endpackage

// File: rtl/l2_port_arbiter_counter.sv
// counter_n: N-bit up counter with synchronous clear (r) and count enable; wraps naturally.
// Clear has priority over enable.
module counter_n #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         r,
  input  logic         en,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (r) begin
      q <= '0;
    end else if (en) begin
      q <= q + N'(1);
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the L2 port among L1I refill, L1D refill and L1D writeback as 8-beat bursts.
// Grant 2 cycles after request, l2_ready=0 stalls the burst in place; L2_ARB_ROUND_ROBIN_EN selects rotating priority.
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int BEATS    = L2_BEATS,
  parameter int CNT_BITS = L2_CNT_BITS,
  parameter int DATA_W   = L2_DATA_W,
  parameter int ADDR_W   = L2_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                req_dr,
  input  logic [ADDR_W-1:0]   addr_dr,
  input  logic                req_dw,
  input  logic [ADDR_W-1:0]   addr_dw,
  input  logic [DATA_W-1:0]   wdata_dw,
  output logic [2:0]          gnt,
  output logic [CNT_BITS-1:0] beat_idx,
  output logic                beat_vld,
  output logic [DATA_W-1:0]   rdata,
  output logic [2:0]          done,
  output logic                l2_req,
  output logic                l2_we,
  output logic [ADDR_W-1:0]   l2_addr,
  output logic [DATA_W-1:0]   l2_wdata,
  input  logic [DATA_W-1:0]   l2_rdata,
  input  logic                l2_ready
);

  localparam int                  LINE_OFF  = $clog2(BEATS * DATA_W / 8);
  localparam logic [ADDR_W-1:0]   LINE_MASK = ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  arb_state_t        state;
  logic [2:0]        reqs;
  logic [1:0]        win;
  logic [ADDR_W-1:0] win_addr;
  logic              cnt_en;
  logic              cnt_clr;

  assign reqs = {req_dw, req_dr, req_i};

`ifdef L2_ARB_ROUND_ROBIN_EN
  // order[2] is highest priority; the previous winner always sits in order[0]
  function automatic logic [1:0] pick_rr(input logic [2:0] r, input logic [1:0] last);
    logic [2:0][1:0] order;
    logic [1:0]      w;
    case (last)
      REQ_I:   order = {REQ_DW, REQ_DR, REQ_I};
      REQ_DR:  order = {REQ_I,  REQ_DW, REQ_DR};
      default: order = {REQ_DR, REQ_I,  REQ_DW};
    endcase
    w = order[0];
    if (r[order[1]]) w = order[1];
    if (r[order[2]]) w = order[2];
    return w;
  endfunction

  logic [1:0] last_win;

  assign win = pick_rr(reqs, last_win);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_win <= REQ_I;
    end else if (state == ST_ARB && |reqs) begin
      last_win <= win;
    end
  end
`else
  // Writeback first so a dirty victim drains before the refill that replaces it
  function automatic logic [1:0] pick_fixed(input logic [2:0] r);
    logic [1:0] w;
    w = REQ_I;
    if (r[REQ_DR]) w = REQ_DR;
    if (r[REQ_DW]) w = REQ_DW;
    return w;
  endfunction

  assign win = pick_fixed(reqs);
`endif

  always_comb begin
    win_addr = addr_i;
    case (win)
      REQ_DR:  win_addr = addr_dr;
      REQ_DW:  win_addr = addr_dw;
      default: win_addr = addr_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      done    <= '0;
      l2_req  <= 1'b0;
      l2_we   <= 1'b0;
      l2_addr <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (|reqs) state <= ST_ARB;
        end
        ST_ARB: begin
          if (|reqs) begin
            gnt     <= 3'b001 << win;
            l2_req  <= 1'b1;
            l2_we   <= (win == REQ_DW);
            l2_addr <= win_addr & LINE_MASK;
            state   <= ST_BURST;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (l2_ready && beat_idx == LAST_BEAT) begin
            done    <= gnt;
            gnt     <= '0;
            l2_req  <= 1'b0;
            l2_we   <= 1'b0;
            l2_addr <= '0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Counter is held at zero outside BURST, so it always starts a burst at beat 0
  assign cnt_en  = (state == ST_BURST) && l2_ready;
  assign cnt_clr = reset || (state != ST_BURST);

  counter_n #(
    .N(CNT_BITS)
  ) u_beat_cnt (
    .clk(clk),
    .r  (cnt_clr),
    .en (cnt_en),
    .q  (beat_idx)
  );

  assign beat_vld = cnt_en;
  assign rdata    = (cnt_en && !l2_we) ? l2_rdata : '0;
  assign l2_wdata = gnt[REQ_DW] ? wdata_dw : '0;

endmodule
